// File: rtl/if_prefetch_unit.sv
// if_prefetch_unit -- decoupled instruction prefetch stage for the RV32I pipeline.
//
// Issues in-order fetch requests to an instruction memory of any latency
// (one cycle or more). Returned words go into a DEPTH-entry queue, and the
// queue head is presented to decode. Execute-stage redirects flush the queue
// and drop every response still in flight.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   stallD              decode not accepting; the head is held
//   redirect_valid/pc   execute-stage PC redirect (taken branch/jump)
//   imem_req_*          fetch request channel (valid/ready/addr)
//   imem_rsp_*          in-order response channel (valid/data)
//   D_valid/instr/pc    queue head for decode (NOP when empty)
//   D_pc_plus_4         D_pc + 4, modulo 2^XLEN
//   q_count             queue occupancy

// Protocol checker: the queue never overflows, and the discard count never
// exceeds the outstanding count.
module if_prefetch_unit_chk #(
  parameter int unsigned CW = 3,
  parameter logic [CW-1:0] FULL = 3'd4
) (
  input logic          clk,
  input logic          rst_n,
  input logic          enq,
  input logic          deq,
  input logic [CW-1:0] count,
  input logic [CW-1:0] outstanding,
  input logic [CW-1:0] discard
);
  // Sample the invariants on every clock edge while out of reset.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(enq && !deq && (count == FULL)));
      assert (discard <= outstanding);
    end
  end
endmodule

module if_prefetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     MAX_OUT  = 2,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0]     NOP      = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stallD,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   imem_req_valid,
  output logic [XLEN-1:0]        imem_req_addr,
  input  logic                   imem_req_ready,
  input  logic                   imem_rsp_valid,
  input  logic [31:0]            imem_rsp_data,
  output logic                   D_valid,
  output logic [31:0]            D_instr,
  output logic [XLEN-1:0]        D_pc,
  output logic [XLEN-1:0]        D_pc_plus_4,
  output logic [$clog2(DEPTH):0] q_count
);
  localparam int unsigned      AW        = $clog2(DEPTH);
  localparam int unsigned      CW        = AW + 1;
  localparam logic [CW-1:0]    CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1'b1);
  localparam logic [CW-1:0]    FULL_W    = CW'(DEPTH);
  localparam logic [CW:0]      DEPTH_W   = (CW+1)'(DEPTH);
  localparam logic [CW-1:0]    MAX_OUT_W = CW'(MAX_OUT);
  localparam logic [AW-1:0]    PTR_ONE   = AW'(1'b1);
  localparam logic [XLEN-1:0]  PC_STEP   = XLEN'(32'd4);

  logic [31:0]     instr_q_r [DEPTH];
  logic [XLEN-1:0] pc_q_r    [DEPTH];
  logic [AW-1:0]   head_r, tail_r;
  logic [CW-1:0]   count_r, outstanding_r, discard_r;
  logic [XLEN-1:0] fetch_pc_r, rsp_pc_r;

  logic            issue_s, rsp_take_s, enq_s, deq_s;
  logic [CW:0]     credit_used_s;
  logic [CW-1:0]   count_nxt_s, out_nxt_s, discard_nxt_s;
  logic [XLEN-1:0] head_pc_s;

  // Issue/accept decisions and next values of the occupancy counters.
  always_comb begin
    credit_used_s  = {1'b0, count_r} + {1'b0, outstanding_r};
    // Queued plus in-flight words never exceed DEPTH, so every response has a slot.
    imem_req_valid = rst_n && (credit_used_s < DEPTH_W) &&
                     (outstanding_r < MAX_OUT_W) && !redirect_valid;
    issue_s        = imem_req_valid && imem_req_ready;
    // Responses with nothing outstanding (e.g. late after a reset) are ignored.
    rsp_take_s     = imem_rsp_valid && (outstanding_r != CNT_ZERO);
    enq_s          = rsp_take_s && (discard_r == CNT_ZERO) && !redirect_valid;
    deq_s          = (count_r != CNT_ZERO) && !stallD && !redirect_valid;

    if (issue_s && !rsp_take_s) begin
      out_nxt_s = outstanding_r + CNT_ONE;
    end else if (!issue_s && rsp_take_s) begin
      out_nxt_s = outstanding_r - CNT_ONE;
    end else begin
      out_nxt_s = outstanding_r;
    end

    if (redirect_valid) begin
      count_nxt_s = CNT_ZERO;
    end else if (enq_s && !deq_s) begin
      count_nxt_s = count_r + CNT_ONE;
    end else if (!enq_s && deq_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end

    // On redirect every word still in flight is stale; no issue happens this cycle.
    if (redirect_valid) begin
      discard_nxt_s = out_nxt_s;
    end else if (rsp_take_s && (discard_r != CNT_ZERO)) begin
      discard_nxt_s = discard_r - CNT_ONE;
    end else begin
      discard_nxt_s = discard_r;
    end
  end

  // Queue head drives decode; an empty queue presents a NOP bubble.
  always_comb begin
    D_valid = (count_r != CNT_ZERO);
    if (D_valid) begin
      D_instr   = instr_q_r[head_r];
      head_pc_s = pc_q_r[head_r];
    end else begin
      D_instr   = NOP;
      head_pc_s = {XLEN{1'b0}};
    end
    D_pc          = head_pc_s;
    D_pc_plus_4   = head_pc_s + PC_STEP;
    imem_req_addr = fetch_pc_r;
    q_count       = count_r;
  end

  // Queue storage, pointers, counters and the fetch/response PC trackers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r        <= {AW{1'b0}};
      tail_r        <= {AW{1'b0}};
      count_r       <= CNT_ZERO;
      outstanding_r <= CNT_ZERO;
      discard_r     <= CNT_ZERO;
      fetch_pc_r    <= RESET_PC;
      rsp_pc_r      <= RESET_PC;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q_r[i] <= NOP;
        pc_q_r[i]    <= {XLEN{1'b0}};
      end
    end else begin
      count_r       <= count_nxt_s;
      outstanding_r <= out_nxt_s;
      discard_r     <= discard_nxt_s;
      if (redirect_valid) begin
        head_r     <= {AW{1'b0}};
        tail_r     <= {AW{1'b0}};
        fetch_pc_r <= redirect_pc;
        rsp_pc_r   <= redirect_pc;
      end else begin
        if (issue_s) begin
          fetch_pc_r <= fetch_pc_r + PC_STEP;
        end
        // Each kept response belongs to the next sequential PC after the last one kept.
        if (enq_s) begin
          instr_q_r[tail_r] <= imem_rsp_data;
          pc_q_r[tail_r]    <= rsp_pc_r;
          tail_r            <= tail_r + PTR_ONE;
          rsp_pc_r          <= rsp_pc_r + PC_STEP;
        end
        if (deq_s) begin
          head_r <= head_r + PTR_ONE;
        end
      end
    end
  end

  if_prefetch_unit_chk #(
    .CW   (CW),
    .FULL (FULL_W)
  ) u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .enq         (enq_s),
    .deq         (deq_s),
    .count       (count_r),
    .outstanding (outstanding_r),
    .discard     (discard_r)
  );
endmodule

// File: doc/if_prefetch_unit.md
Name: if_prefetch_unit

Overview:
- Parametrised successor to the single-register fetch stage (PC register + IF/ID latch) of the 5-stage RV32I pipeline.
- Decouples instruction fetch from decode:
  - issues in-order requests to an instruction memory of arbitrary latency (≥1 cycle);
  - buffers returned words in a DEPTH-entry queue;
  - presents the queue head to decode.
- Handles decode stalls and execute-stage redirects (branch/jump, the E_PCSrc/E_pcTarget path), including discarding responses still in flight.

Parameters:
- XLEN, 32, data/address width.
- DEPTH, 4, instruction queue entries (power of 2, ≥2).
- MAX_OUT, 2, maximum outstanding memory requests (1..DEPTH).
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP, 32'h0000_0013, word driven on D_instr when D_valid=0 (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stallD  in  1  decode not accepting; head held.
- redirect_valid  in  1  execute-stage PC redirect (taken branch/jump).
- redirect_pc  in  XLEN  redirect target, word aligned.
- imem_req_valid  out  1  fetch request.
- imem_req_addr  out  XLEN  fetch address.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_rsp_valid  in  1  response word valid; responses return in request order.
- imem_rsp_data  in  32  instruction word.
- D_valid  out  1  D_instr/D_pc hold a valid instruction.
- D_instr  out  32  head instruction, or NOP when D_valid=0.
- D_pc  out  XLEN  PC of head instruction.
- D_pc_plus_4  out  XLEN  D_pc+4, modulo 2^XLEN.
- q_count  out  $clog2(DEPTH)+1  queue occupancy (debug/perf).

Behaviour:
- Reset (async, rst_n=0) clears everything:
  - fetch_pc=RESET_PC; queue empty; outstanding=0; discard=0.
  - Outputs: imem_req_valid=0, D_valid=0, D_instr=NOP, D_pc=0, D_pc_plus_4=4, q_count=0, imem_req_addr=RESET_PC.
  - Reset asserted mid-operation drops all in-flight state. Responses arriving afterwards count against outstanding=0 and are ignored.
- Issue:
  - imem_req_valid=1 when (q_count + outstanding) < DEPTH, outstanding < MAX_OUT, and redirect_valid=0.
  - Handshake completes when imem_req_valid && imem_req_ready. On completion: fetch_pc += 4 (wraps modulo 2^XLEN), outstanding++.
  - imem_req_addr=fetch_pc. Addr and valid are held stable while ready=0.
- Response:
  - imem_rsp_valid decrements outstanding.
  - If discard>0: the word is dropped and discard is decremented.
  - Otherwise the word is enqueued with its PC (tracked by a separate rsp_pc counter incremented per accepted response).
- Credit rule guarantees no overflow; a response arriving when full is a protocol error (assertion).
- Dequeue: head leaves when D_valid && !stallD. Outputs are combinational from the queue head; latency from rsp_valid to D_valid is 1 cycle.
- Simultaneous enqueue+dequeue: occupancy unchanged. Dequeue+enqueue when full is legal (count unchanged).
- Redirect (redirect_valid=1), takes priority over stall, issue and enqueue:
  - Next edge: queue flushed (q_count=0, D_valid=0); fetch_pc=rsp_pc=redirect_pc.
  - discard = outstanding after this cycle's decrement, i.e. outstanding − (imem_rsp_valid?1:0) + 0. No issue occurs in a redirect cycle.
  - A response arriving in the redirect cycle is itself dropped.
  - Back-to-back redirects: the last one wins; discard accumulates correctly.
  - First new request is issued the cycle after the redirect.
- Empty: D_valid=0 and D_instr=NOP, which acts as a pipeline bubble; stallD is ignored.
- Full: imem_req_valid=0 until a dequeue frees credit.
- Steady state with 1-cycle memory, ready=1, MAX_OUT≥2 and no stalls: one instruction per cycle.

Test Plan:
- Release reset, memory latency 1, ready=1, no stall.
  - Required: imem_req_addr 0x0,0x4,0x8… on consecutive cycles.
  - Required: D_valid first high 2 cycles after first request, D_pc=0x0, then one instruction per cycle.
- Hold stallD=1 for 10 cycles with DEPTH=4.
  - Required: q_count saturates at 4; imem_req_valid falls.
  - Required: D_pc frozen; after release, PCs continue with no gaps or duplicates.
- Memory latency 3, MAX_OUT=2; pulse redirect_valid with redirect_pc=0x100 while 2 requests are outstanding.
  - Required: both stale responses dropped; next D_pc=0x100; D_valid=0 in between.
- Redirect in the same cycle as imem_rsp_valid and stallD=1.
  - Required: response dropped, queue flushed, discard = remaining outstanding, next fetch address = redirect_pc.
- imem_req_ready held low for 5 cycles.
  - Required: imem_req_addr stable, fetch_pc not advanced, no phantom entries in the queue.
- Assert rst_n=0 mid-stream with 2 requests outstanding, release, then deliver late responses.
  - Required: late responses ignored; fetch restarts at RESET_PC; D_valid=0 until the new response arrives.
